// File: rtl/wire_path_arbiter.sv
// wire_path_arbiter: round-robin arbiter sharing one repeater/inverter wire path among NREQ requesters
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req[NREQ]           request levels, held high while a requester wants the path
//   data_in[NREQ]       per-requester data bit
//   inv_sel[NREQ]       per-requester mode: 0 repeat, 1 invert
//   grant[NREQ]         one-hot grant, zero when the path is idle
//   out_wire            granted bit (optionally inverted), one cycle after the grant
//   out_valid           out_wire carries granted data
//   path_sel            inv_sel of the granted requester (0 repeater, 1 inverter)
//   busy                arbiter is not IDLE
// Build option: WIRE_ARB_GAP_EN inserts a one-cycle GAP state after every release.
module wire_path_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] data_in,
  input  logic [NREQ-1:0] inv_sel,
  output logic [NREQ-1:0] grant,
  output logic            out_wire,
  output logic            out_valid,
  output logic            path_sel,
  output logic            busy
);
  localparam int PW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
`ifdef WIRE_ARB_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  logic [1:0] state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, own_q, own_d, base, win;
  logic [HW-1:0] hold_q, hold_d;
  logic rel, arb, out_wire_q, out_valid_q, path_sel_q;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] x);
    return PW'((int'(x) + 1) % NREQ);
  endfunction
  // First set request bit searching upward from b, wrapping modulo NREQ.
  function automatic logic [PW-1:0] pick(input logic [NREQ-1:0] r, input logic [PW-1:0] b);
    logic [PW-1:0] w;
    logic f;
    int k;
    w = '0;
    f = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(b) + i) % NREQ;
      if (!f && r[k]) begin
        w = PW'(k);
        f = 1'b1;
      end
    end
    return w;
  endfunction
  // On release the pointer moves past the owner and, without the gap, the
  // very same edge re-arbitrates from that new pointer.
  always_comb begin
    rel     = (state_q == GRANT) && (!req[own_q] || hold_q == HW'(MAX_HOLD - 1));
    base    = rel ? inc(own_q) : ptr_q;
    win     = pick(req, base);
    arb     = (state_q != GRANT) || (rel && !GAP_EN);
    ptr_d   = base;
    own_d   = (arb && |req) ? win : own_q;
    hold_d  = (state_q == GRANT && !rel) ? hold_q + 1'b1 : '0;
    state_d = arb ? (|req ? GRANT : IDLE) : (rel ? GAP : state_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      own_q       <= '0;
      hold_q      <= '0;
      out_wire_q  <= 1'b0;
      out_valid_q <= 1'b0;
      path_sel_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      own_q       <= own_d;
      hold_q      <= hold_d;
      out_valid_q <= state_q == GRANT;
      out_wire_q  <= (state_q == GRANT) && (data_in[own_q] ^ inv_sel[own_q]);
      path_sel_q  <= (state_q == GRANT) && inv_sel[own_q];
    end
  end
  assign grant     = (state_q == GRANT) ? {{(NREQ-1){1'b0}}, 1'b1} << own_q : '0;
  assign busy      = state_q != IDLE;
  assign out_wire  = out_wire_q;
  assign out_valid = out_valid_q;
  assign path_sel  = path_sel_q;
endmodule

// File: tb/tb_wire_path_arbiter.sv
// tb_wire_path_arbiter: scoreboard bench for wire_path_arbiter (NREQ=4, MAX_HOLD=8)
module tb_wire_path_arbiter;
  localparam int N = 4;
  localparam int MH = 8;
`ifdef WIRE_ARB_GAP_EN
  localparam bit GAPM = 1'b1;
`else
  localparam bit GAPM = 1'b0;
`endif
  typedef struct packed {
    logic [3:0] g;
    logic       b;
    logic       ov;
    logic       ow;
    logic       ps;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0, data_in = '0, inv_sel = '0, grant;
  logic out_wire, out_valid, path_sel, busy;
  int n_cmp = 0, n_bad = 0;
  int m_st = 0, m_ptr = 0, m_own = 0, m_hold = 0;
  exp_t sb[$];
  wire_path_arbiter #(.NREQ(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .inv_sel(inv_sel),
    .grant(grant), .out_wire(out_wire), .out_valid(out_valid), .path_sel(path_sel), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int first_from(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction
  task automatic model_reset();
    m_st = 0; m_ptr = 0; m_own = 0; m_hold = 0;
  endtask
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] d, input logic [N-1:0] v);
    exp_t e, o;
    int w;
    req = r; data_in = d; inv_sel = v;
    e.ov = m_st == 1;
    e.ow = (m_st == 1) ? d[m_own] ^ v[m_own] : 1'b0;
    e.ps = (m_st == 1) ? v[m_own] : 1'b0;
    if (m_st == 1) begin
      if (!r[m_own] || m_hold == MH - 1) begin
        m_ptr = (m_own + 1) % N;
        if (GAPM) m_st = 2;
        else begin
          w = first_from(r, m_ptr);
          if (w < 0) m_st = 0;
          else begin m_own = w; m_hold = 0; end
        end
      end else m_hold++;
    end else begin
      w = first_from(r, m_ptr);
      if (w < 0) m_st = 0;
      else begin m_st = 1; m_own = w; m_hold = 0; end
    end
    e.g = (m_st == 1) ? 4'(1 << m_own) : 4'd0;
    e.b = m_st != 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk("grant", 8'(grant), 8'(o.g));
    chk("busy", 8'(busy), 8'(o.b));
    chk("out_valid", 8'(out_valid), 8'(o.ov));
    if (o.ov) begin
      chk("out_wire", 8'(out_wire), 8'(o.ow));
      chk("path_sel", 8'(path_sel), 8'(o.ps));
    end
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant", 8'(grant), 8'd0);
    chk("rst_valid", 8'(out_valid), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_wire", 8'(out_wire), 8'd0);
    chk("rst_psel", 8'(path_sel), 8'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    logic [2:0] pat;
    pat = 3'b101;
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b0001, 4'(i & 1), 4'b1111);
    repeat (3) step(4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 40; i++) step(4'b1111, 4'($urandom), 4'($urandom));
    repeat (3) step(4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 20; i++) step(4'b0100, 4'($urandom), 4'($urandom));
    step(4'b0000, 4'b0000, 4'b0000);
    do_reset();
    repeat (2) step(4'b0011, 4'($urandom), 4'($urandom));
    repeat (3) step(4'b0010, 4'($urandom), 4'($urandom));
    chk("handoff_grant", 8'(grant), 8'h02);
    do_reset();
    for (int i = 0; i < 6; i++) step(4'b1111, 4'($urandom), 4'($urandom));
    for (int i = 2; i >= 0; i--) step(4'b1000, {pat[i], 3'b000}, 4'b0000);
    repeat (3) step(4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 12; i++) step(4'($urandom), 4'($urandom), 4'($urandom));
    repeat (2) step(4'b0000, 4'b0000, 4'b0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wire_path_arbiter.md
# wire_path_arbiter

Round-robin arbiter that shares the single-bit repeater/inverter wire path between NREQ requesters. Each cycle it forwards the granted requester's bit to one registered output, optionally inverted according to that requester's mode bit. Grants are time-limited by a hold counter so that no requester can monopolise the path. It sits between the test/stimulus sources and the repeater/inverter pair.

## Interface
- NREQ, 4, number of requesters, legal range 2..8
- MAX_HOLD, 8, maximum consecutive GRANT cycles per grant, legal range ≥1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NREQ  per-requester request level, held high while wanting the path
- data_in  input  NREQ  per-requester data bit
- inv_sel  input  NREQ  per-requester mode: 0 = repeat, 1 = invert
- grant  output  NREQ  one-hot grant, registered; all-zero when path idle
- out_wire  output  1  registered path output: data_in[g] ^ inv_sel[g] of the requester granted in the previous cycle
- out_valid  output  1  registered; high when out_wire carries granted data
- path_sel  output  1  registered; inv_sel of the granted requester (0 selects the repeater, 1 the inverter)
- busy  output  1  high in any state other than IDLE

## Operation
- Clock is clk; reset is asynchronous, active-low (rst_n).
- States:
  - IDLE: grant = 0.
  - GRANT: exactly one grant bit set.
  - GAP: grant = 0; one cycle only; exists only with the macro defined.
- Round-robin pointer ptr, width clog2(NREQ), reset 0. The winner is the first set req bit searching ptr, ptr+1, … modulo NREQ.
- IDLE → GRANT: at the first edge where any req is high. grant = onehot(winner), hold_cnt = 0.
- In GRANT, with g the current owner, at each edge:
  - Release if req[g] = 0 or hold_cnt = MAX_HOLD-1.
  - Otherwise hold_cnt += 1 and the grant is unchanged.
- On release, ptr = (g+1) mod NREQ. The next state depends on the configuration (see Configuration).
- The owner's req and data_in are sampled each edge. Changes to inv_sel during a grant take effect on the next edge.
- hold_cnt width is clog2(MAX_HOLD)+1; it never wraps.
- MAX_HOLD = 1 yields a single-cycle grant per arbitration.
- If all req bits are 0 at the release edge, the next state is IDLE.
- A requester that drops req and re-raises it later waits its round-robin turn.

## Timing
- Reset values:
  - grant = 0, out_wire = 0, out_valid = 0, path_sel = 0, busy = 0.
  - State = IDLE, ptr = 0, hold_cnt = 0.
- Reset is effective immediately on rst_n low, mid-grant included. The first grant is possible at the first edge after rst_n rises with req high.
- Arbitration latency: req high at edge k while IDLE → grant visible after edge k.
- Data latency: one cycle after grant. out_valid/out_wire/path_sel at edge k+1 reflect the grant and inputs present during cycle k.
- out_valid falls one cycle after grant goes to zero.
- Maximum continuous ownership is MAX_HOLD cycles.

## Configuration
- WIRE_ARB_GAP_EN defined:
  - Every release goes through one GAP cycle (grant = 0, busy = 1), then arbitrates at the next edge → GRANT or IDLE.
  - out_valid shows a one-cycle low bubble between owners.
- WIRE_ARB_GAP_EN undefined:
  - Release arbitrates at the release edge itself. The next owner's grant appears in the following cycle with no bubble.
  - If the same requester is the only one requesting, it is re-granted back-to-back with hold_cnt = 0.

## Test plan
- Single requester: NREQ=4, MAX_HOLD=8, req=0001 for 3 cycles, data_in[0] toggling, inv_sel[0]=1 → grant=0001 for 3 cycles; out_wire = inverted data, one cycle late; out_valid high for 3 cycles; path_sel=1.
- Round robin: req=1111 held → grant order 0001, 0010, 0100, 1000, 0001, each lasting 8 cycles. With WIRE_ARB_GAP_EN there is a 1-cycle grant=0 between owners; without, there is none.
- Hold limit with sole requester: req=0100 held, MAX_HOLD=3, macro undefined → grant=0100 continuously and hold_cnt sequence 0,1,2,0,1,2. With the macro: 3 cycles granted, 1 cycle GAP, repeating.
- Early release: req=0011, requester 0 drops req after 2 cycles → grant 0001 for 2 cycles, then 0010; ptr = 1 after the handoff.
- Async reset mid-grant: assert rst_n=0 between edges while grant=0010 → grant/out_valid/busy = 0 immediately. After release, req=1111 → first grant 0001.
- Repeat mode: inv_sel=0, data_in[g] pattern 1,0,1 → out_wire 1,0,1 delayed one cycle; path_sel=0.
